// File: rtl/ila_capture_ctrl_pkg.sv
// Shared types and constants for the ILA capture sequencer.
package ila_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRETRIG   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POSTTRIG  = 3'd3,
        ST_DONE      = 3'd4
    } ila_state_t;

    localparam logic TRIG_LEVEL = 1'b0;
    localparam logic TRIG_EDGE  = 1'b1;

    // Pick the trigger source for the configured mode.
    function automatic logic trig_select(input logic mode, input logic level_hit, input logic edge_hit);
        logic r;
        r = level_hit;
        case (mode)
            TRIG_LEVEL: r = level_hit;
            TRIG_EDGE:  r = edge_hit;
            default:    r = level_hit;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ila_trigger_match.sv
// Masked compare of the probe bus, delayed to line up with the BRAM data path,
// plus one cycle of match history for edge detection.
module ila_trigger_match #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PIPE_DEPTH = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    output logic                  match_c,
    output logic                  edge_c
);

    logic raw_match_c;
    logic prev_match;

    assign raw_match_c = (((sample ^ trig_value) & trig_mask) == '0);

    generate
        if (PIPE_DEPTH == 0) begin : g_nopipe
            assign match_c = raw_match_c;
        end else begin : g_pipe
            logic [PIPE_DEPTH-1:0] pipe;

            // Delay line matching the BRAM input pipeline.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pipe <= '0;
                end else begin
                    pipe[0] <= raw_match_c;
                    for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign match_c = pipe[PIPE_DEPTH-1];
        end
    endgenerate

    // History runs every cycle regardless of capture state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_match <= 1'b0;
        end else begin
            prev_match <= match_c;
        end
    end

    assign edge_c = match_c & ~prev_match;

endmodule

// File: rtl/ila_capture_ctrl.sv
// Capture sequencer for the ILA sample BRAM: ring fill, trigger wait,
// post-trigger fill, then hold results for readout.
module ila_capture_ctrl
    import ila_capture_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned PIPE_DEPTH = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  force_trig,
    input  logic [ADDR_WIDTH-1:0] pre_trig_cnt,
    input  logic                  trig_mode,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr_write,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] start_addr
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    ila_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] cfg_pre, cfg_pre_nxt;
    logic                  cfg_mode, cfg_mode_nxt;
    logic [DATA_WIDTH-1:0] cfg_mask, cfg_mask_nxt;
    logic [DATA_WIDTH-1:0] cfg_value, cfg_value_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;

    logic                  we_nxt, busy_nxt, triggered_nxt, done_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt, trig_addr_nxt, start_addr_nxt;

    logic          match_c, edge_c, hit_c;
    logic [CW-1:0] cnt_inc_c, post_total_c;

    ila_trigger_match #(
        .DATA_WIDTH(DATA_WIDTH),
        .PIPE_DEPTH(PIPE_DEPTH)
    ) u_match (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample    (sample),
        .trig_mask (cfg_mask),
        .trig_value(cfg_value),
        .match_c   (match_c),
        .edge_c    (edge_c)
    );

    assign hit_c        = trig_select(cfg_mode, match_c, edge_c) | force_trig;
    assign cnt_inc_c    = cnt + CW'(1);
    assign post_total_c = CW'(DEPTH - 1) - {1'b0, cfg_pre};

    always_comb begin
        state_nxt      = state;
        cfg_pre_nxt    = cfg_pre;
        cfg_mode_nxt   = cfg_mode;
        cfg_mask_nxt   = cfg_mask;
        cfg_value_nxt  = cfg_value;
        cnt_nxt        = cnt;
        we_nxt         = we;
        busy_nxt       = busy;
        triggered_nxt  = triggered;
        done_nxt       = done;
        addr_nxt       = addr_write;
        trig_addr_nxt  = trig_addr;
        start_addr_nxt = start_addr;

        if (abort) begin
            state_nxt     = ST_IDLE;
            we_nxt        = 1'b0;
            busy_nxt      = 1'b0;
            triggered_nxt = 1'b0;
            done_nxt      = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_nxt     = (pre_trig_cnt == '0) ? ST_WAIT_TRIG : ST_PRETRIG;
                        cfg_pre_nxt   = pre_trig_cnt;
                        cfg_mode_nxt  = trig_mode;
                        cfg_mask_nxt  = trig_mask;
                        cfg_value_nxt = trig_value;
                        cnt_nxt       = '0;
                        addr_nxt      = '0;
                        we_nxt        = 1'b1;
                        busy_nxt      = 1'b1;
                        triggered_nxt = 1'b0;
                        done_nxt      = 1'b0;
                    end
                end
                ST_PRETRIG: begin
                    addr_nxt = addr_write + ADDR_WIDTH'(1);
                    if (cnt_inc_c == {1'b0, cfg_pre}) begin
                        state_nxt = ST_WAIT_TRIG;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc_c;
                    end
                end
                ST_WAIT_TRIG: begin
                    addr_nxt = addr_write + ADDR_WIDTH'(1);
                    if (hit_c) begin
                        trig_addr_nxt  = addr_write;
                        start_addr_nxt = addr_write - cfg_pre;
                        triggered_nxt  = 1'b1;
                        cnt_nxt        = '0;
                        if (post_total_c == '0) begin
                            state_nxt = ST_DONE;
                            we_nxt    = 1'b0;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_POSTTRIG;
                        end
                    end
                end
                ST_POSTTRIG: begin
                    addr_nxt = addr_write + ADDR_WIDTH'(1);
                    cnt_nxt  = cnt_inc_c;
                    if (cnt_inc_c == post_total_c) begin
                        state_nxt = ST_DONE;
                        we_nxt    = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    we_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cfg_pre    <= '0;
            cfg_mode   <= 1'b0;
            cfg_mask   <= '0;
            cfg_value  <= '0;
            cnt        <= '0;
            we         <= 1'b0;
            busy       <= 1'b0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            addr_write <= '0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else begin
            state      <= state_nxt;
            cfg_pre    <= cfg_pre_nxt;
            cfg_mode   <= cfg_mode_nxt;
            cfg_mask   <= cfg_mask_nxt;
            cfg_value  <= cfg_value_nxt;
            cnt        <= cnt_nxt;
            we         <= we_nxt;
            busy       <= busy_nxt;
            triggered  <= triggered_nxt;
            done       <= done_nxt;
            addr_write <= addr_nxt;
            trig_addr  <= trig_addr_nxt;
            start_addr <= start_addr_nxt;
        end
    end

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Bench for ila_capture_ctrl: two instances (no data pipeline and a 2-stage one)
// driven in lockstep, each compared against a write-count level reference model.
module tb_ila_capture_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, arm, abort, force_trig, trig_mode;
    logic [AW-1:0] pre_trig_cnt;
    logic [DW-1:0] trig_mask, trig_value, sample;

    logic [1:0]         we_v, busy_v, trig_v, done_v;
    logic [1:0][AW-1:0] addr_v, taddr_v, saddr_v;

    ila_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIPE_DEPTH(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .force_trig(force_trig),
        .pre_trig_cnt(pre_trig_cnt), .trig_mode(trig_mode), .trig_mask(trig_mask),
        .trig_value(trig_value), .sample(sample), .we(we_v[0]), .addr_write(addr_v[0]),
        .busy(busy_v[0]), .triggered(trig_v[0]), .done(done_v[0]),
        .trig_addr(taddr_v[0]), .start_addr(saddr_v[0])
    );

    ila_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIPE_DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .force_trig(force_trig),
        .pre_trig_cnt(pre_trig_cnt), .trig_mode(trig_mode), .trig_mask(trig_mask),
        .trig_value(trig_value), .sample(sample), .we(we_v[1]), .addr_write(addr_v[1]),
        .busy(busy_v[1]), .triggered(trig_v[1]), .done(done_v[1]),
        .trig_addr(taddr_v[1]), .start_addr(saddr_v[1])
    );

    int errors = 0;
    int checks = 0;
    int wr0    = 0;
    logic [DW-1:0] r_val;

    // Reference model state, one slot per instance
    logic [DW-1:0] m_mask [2];
    logic [DW-1:0] m_value[2];
    logic          m_mode [2];
    int            m_pre  [2];
    bit            m_act[2], m_done[2], m_trig[2], m_rst[2], m_newdone[2];
    int            m_k[2], m_tk[2];
    logic [AW-1:0] m_taddr[2], m_saddr[2];
    bit            mh[2][2];
    bit            mprev[2];
    logic [DW-1:0] sh[2];
    logic [DW-1:0] ring[2][DEPTH];
    logic [DW-1:0] mem [2][DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic model_step();
        bit raw, al, hit;
        logic [DW-1:0] dat;
        for (int j = 0; j < 2; j++) begin
            m_newdone[j] = 0;
            raw = (((sample ^ m_value[j]) & m_mask[j]) == '0);
            al  = (j == 0) ? raw : mh[j][1];
            dat = (j == 0) ? sample : sh[1];
            if (!rst_n) begin
                m_act[j] = 0; m_done[j] = 0; m_trig[j] = 0; m_rst[j] = 1;
                m_mask[j] = '0; m_value[j] = '0; m_mode[j] = 0; m_pre[j] = 0;
                m_taddr[j] = '0; m_saddr[j] = '0;
                mh[j][0] = 0; mh[j][1] = 0; mprev[j] = 0;
            end else begin
                if (abort) begin
                    m_act[j] = 0; m_done[j] = 0; m_trig[j] = 0;
                end else if (arm && !m_act[j]) begin
                    m_mask[j] = trig_mask; m_value[j] = trig_value;
                    m_mode[j] = trig_mode; m_pre[j] = int'(pre_trig_cnt);
                    m_act[j] = 1; m_done[j] = 0; m_trig[j] = 0; m_rst[j] = 0;
                    m_k[j] = 0; m_tk[j] = -1;
                end else if (m_act[j]) begin
                    ring[j][m_k[j] % DEPTH] = dat;
                    hit = (m_mode[j] ? (al && !mprev[j]) : al) || force_trig;
                    if (m_tk[j] < 0 && m_k[j] >= m_pre[j] && hit) begin
                        m_tk[j]    = m_k[j];
                        m_trig[j]  = 1;
                        m_taddr[j] = AW'(m_k[j] % DEPTH);
                        m_saddr[j] = AW'((m_k[j] - m_pre[j]) % DEPTH);
                    end
                    m_k[j]++;
                    // DEPTH writes in total, ending pre+1+post after the window start
                    if (m_tk[j] >= 0 && m_k[j] == m_tk[j] + int'(DEPTH) - m_pre[j]) begin
                        m_act[j] = 0; m_done[j] = 1; m_newdone[j] = 1;
                    end
                end
                mh[j][1] = mh[j][0];
                mh[j][0] = raw;
                mprev[j] = al;
            end
        end
        sh[1] = sh[0];
        sh[0] = sample;
    endtask

    task automatic check_all();
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("we%0d", j), 32'(we_v[j]), 32'(m_act[j]));
            chk($sformatf("busy%0d", j), 32'(busy_v[j]), 32'(m_act[j]));
            chk($sformatf("done%0d", j), 32'(done_v[j]), 32'(m_done[j]));
            chk($sformatf("triggered%0d", j), 32'(trig_v[j]), 32'(m_trig[j]));
            if (m_act[j] || m_rst[j])
                chk($sformatf("addr%0d", j), 32'(addr_v[j]), m_act[j] ? 32'(m_k[j] % DEPTH) : 32'd0);
            if (m_done[j] || m_rst[j]) begin
                chk($sformatf("trig_addr%0d", j), 32'(taddr_v[j]), 32'(m_taddr[j]));
                chk($sformatf("start_addr%0d", j), 32'(saddr_v[j]), 32'(m_saddr[j]));
            end
            if (m_newdone[j]) begin
                for (int a = 0; a < int'(DEPTH); a++) begin
                    int idx;
                    idx = (int'(m_saddr[j]) + a) % DEPTH;
                    chk($sformatf("readback%0d_%0d", j, a), 32'(mem[j][idx]), 32'(ring[j][idx]));
                end
            end
        end
    endtask

    // One clock: BRAM model write, model update, edge, then compare.
    task automatic cycle();
        if (we_v[0] === 1'b1) begin
            mem[0][addr_v[0]] = sample;
            wr0++;
        end
        if (we_v[1] === 1'b1) mem[1][addr_v[1]] = sh[1];
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic arm_it();
        wr0 = 0;
        arm = 1'b1;
        cycle();
        arm = 1'b0;
    endtask

    // Drive a sample pattern until both instances leave the busy states.
    task automatic run(input int pat, input int budget);
        int n = 0;
        while (busy_v != 2'b00 && n < budget) begin
            case (pat)
                0: sample = DW'(n);
                1: sample = 8'h55;
                2: sample = ($urandom_range(0, 2) == 0) ? r_val : DW'($urandom);
                3: sample = (n == 3 || n == 20) ? 8'h55 : 8'h00;
                default: begin
                    sample     = (n == 100) ? 8'h00 : 8'h55;
                    force_trig = (n == 1);
                end
            endcase
            if (pat == 2) begin
                pre_trig_cnt = AW'($urandom);
                trig_mask    = DW'($urandom);
                trig_value   = DW'($urandom);
                trig_mode    = 1'($urandom);
                force_trig   = (n > 150) || ($urandom_range(0, 99) == 0);
                arm          = (busy_v == 2'b11) && ($urandom_range(0, 19) == 0);
                abort        = ($urandom_range(0, 299) == 0);
            end
            cycle();
            n++;
            force_trig = 1'b0;
            arm        = 1'b0;
            abort      = 1'b0;
        end
        if (busy_v != 2'b00) chk("timeout", 32'(busy_v), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; force_trig = 1'b0; trig_mode = 1'b0;
        pre_trig_cnt = '0; trig_mask = '0; trig_value = '0; sample = '0;
        repeat (3) cycle();
        chk("reset_flags", 32'({we_v, busy_v, done_v, trig_v}), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Level trigger on a counting probe
        pre_trig_cnt = 4; trig_mask = 8'hFF; trig_value = 8'h55; trig_mode = 1'b0;
        arm_it();
        run(0, 200);
        chk("t1_trig_addr", 32'(taddr_v[0]), 32'd5);
        chk("t1_start_addr", 32'(saddr_v[0]), 32'd1);
        chk("t5_trig_word", 32'(mem[1][taddr_v[1]]), 32'h55);

        // Match inside the pre window is ignored
        pre_trig_cnt = 8;
        arm_it();
        run(3, 200);
        chk("t2_trig_addr", 32'(taddr_v[0]), 32'd4);
        chk("t2_start_addr", 32'(saddr_v[0]), 32'd12);

        // Edge mode with a held match and a forced trigger in the pre window
        trig_mode = 1'b1; pre_trig_cnt = 4; sample = 8'h55;
        cycle();
        arm_it();
        run(4, 300);
        chk("t3_trig_addr", 32'(taddr_v[0]), 32'd5);

        // Pre window boundaries
        trig_mode = 1'b0; pre_trig_cnt = 0; sample = 8'h55;
        arm_it();
        run(1, 200);
        chk("t4_pre0_writes", 32'(wr0), 32'd16);
        chk("t4_pre0_trig_addr", 32'(taddr_v[0]), 32'd0);
        chk("t4_pre0_start_addr", 32'(saddr_v[0]), 32'd0);
        pre_trig_cnt = 15;
        arm_it();
        run(1, 200);
        chk("t4_pre15_writes", 32'(wr0), 32'd16);
        chk("t4_pre15_trig_addr", 32'(taddr_v[0]), 32'd15);
        chk("t4_pre15_start_addr", 32'(saddr_v[0]), 32'd0);

        // Abort during post-trigger fill
        pre_trig_cnt = 2;
        arm_it();
        repeat (6) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("t6_abort", 32'({we_v[0], busy_v[0], done_v[0], trig_v[0]}), 32'd0);

        // Reset mid-capture
        arm_it();
        repeat (5) cycle();
        rst_n = 1'b0;
        cycle();
        chk("t6_reset", {we_v, busy_v, done_v, trig_v, addr_v, taddr_v, saddr_v}, 32'd0);
        rst_n = 1'b1;
        cycle();

        // Arm and abort together
        pre_trig_cnt = 3;
        arm = 1'b1; abort = 1'b1;
        cycle();
        arm = 1'b0; abort = 1'b0;
        chk("t6_arm_abort", 32'(busy_v), 32'd0);
        cycle();
        chk("t6_arm_abort_hold", 32'(busy_v), 32'd0);

        // Arm while busy does not restart
        pre_trig_cnt = 8;
        arm_it();
        repeat (5) cycle();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        chk("t6_arm_busy_addr", 32'(addr_v[0]), 32'd6);
        run(1, 200);

        // Randomized captures with config churn while busy
        for (int r = 0; r < 40; r++) begin
            pre_trig_cnt = AW'($urandom);
            trig_mode    = 1'($urandom);
            trig_mask    = DW'($urandom);
            trig_value   = DW'($urandom);
            r_val        = trig_value;
            arm_it();
            run(2, 400);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
